// File: rtl/dm_lsu.sv
// dm_lsu: word-array data memory with byte/half/word stores, sign/zero-extended loads, valid/ready
// request port and a one-cycle response pulse LATENCY edges after acceptance; wipes itself after reset.
// Optional macro DM_TRACE_EN: prints every committed store.
module dm_lsu #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        clear_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
    localparam state_t ACC_STATE = (LATENCY == 1) ? RESP : WAIT;

    state_t state, state_nxt;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] clear_idx;
    logic [3:0]        cnt;
    logic              accept;
    logic              commit;

    logic              q_we;
    logic [1:0]        q_size;
    logic              q_uns;
    logic [31:0]       q_addr;
    logic [31:0]       q_wdata;
    logic [31:0]       q_pc;

    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       old_word;
    logic [31:0]       wrep;
    logic [31:0]       merged;
    logic [31:0]       shifted;
    logic [31:0]       ext;

    assign accept     = req_valid & req_ready;
    // The edge leaving RESP is the commit/sample edge; the response pulse follows it.
    assign commit     = (state == RESP);
    assign clear_busy = (state == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            CLEAR: begin
                if (&clear_idx) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ACC_STATE;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                req_ready = 1'b1;
                state_nxt = req_valid ? ACC_STATE : IDLE;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_idx <= '0;
            cnt       <= 4'd0;
            q_we      <= 1'b0;
            q_size    <= 2'b00;
            q_uns     <= 1'b0;
            q_addr    <= 32'd0;
            q_wdata   <= 32'd0;
            q_pc      <= 32'd0;
        end else begin
            if (state == CLEAR) begin
                clear_idx <= clear_idx + 1'b1;
            end
            if (accept) begin
                cnt     <= CNT_INIT;
                q_we    <= req_we;
                q_size  <= req_size;
                q_uns   <= req_unsigned;
                q_addr  <= req_addr;
                q_wdata <= req_wdata;
                q_pc    <= req_pc;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign idx      = q_addr[ADDR_W+1:2];
    assign lane     = q_addr[1:0];
    assign old_word = mem[idx];

    always_comb begin
        err  = (q_addr >> (ADDR_W + 2)) != 32'd0;
        be   = 4'b0000;
        wrep = q_wdata;
        case (q_size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wrep = {4{q_wdata[7:0]}};
            end
            2'b01: begin
                be   = q_addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{q_wdata[15:0]}};
                err  = err | q_addr[0];
            end
            2'b10: begin
                be  = 4'b1111;
                err = err | (lane != 2'b00);
            end
            default: err = 1'b1;
        endcase
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = wrep[i*8 +: 8];
            end
        end
    end

    always_comb begin
        shifted = old_word >> {lane, 3'b000};
        case (q_size)
            2'b00:   ext = {{24{shifted[7] & ~q_uns}}, shifted[7:0]};
            2'b01:   ext = {{16{shifted[15] & ~q_uns}}, shifted[15:0]};
            default: ext = old_word;
        endcase
    end

    // No reset on the array: the CLEAR sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clear_idx] <= 32'd0;
        end else if (commit && q_we && !err) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= commit;
            rsp_err   <= commit & err;
            rsp_rdata <= (commit && !q_we && !err) ? ext : 32'd0;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && commit && q_we && !err) begin
            $display("@%h: *%h <= %h", q_pc, {q_addr[31:2], 2'b00}, merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^q_pc;
`endif

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: one instance at LATENCY=1 (functional vectors), one at LATENCY=3 (timing, reset abort).
module tb_dm_lsu;
    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        a_valid = 1'b0, a_ready, a_we = 1'b0, a_uns = 1'b0;
    logic [1:0]  a_size = 2'b10;
    logic [31:0] a_addr = 32'd0, a_wdata = 32'd0, a_pc = 32'h0000_3010;
    logic        a_rsp_valid, a_err, a_busy;
    logic [31:0] a_rdata;

    logic        b_valid = 1'b0, b_ready, b_we = 1'b0, b_uns = 1'b0;
    logic [1:0]  b_size = 2'b10;
    logic [31:0] b_addr = 32'd0, b_wdata = 32'd0, b_pc = 32'h0000_3010;
    logic        b_rsp_valid, b_err, b_busy;
    logic [31:0] b_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_lsu #(.ADDR_W(12), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_size(a_size),
        .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata), .req_pc(a_pc),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err), .clear_busy(a_busy)
    );

    dm_lsu #(.ADDR_W(12), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_size(b_size),
        .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata), .req_pc(b_pc),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err), .clear_busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to the selected instance and return its response.
    task automatic do_req(input bit s3, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er);
        int n;
        rd = 32'hxxxx_xxxx;
        er = 1'bx;
        if (s3) begin
            b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata; b_valid = 1'b1;
        end else begin
            a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata; a_valid = 1'b1;
        end
        n = 0;
        while (!(s3 ? b_ready : a_ready) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 32'd1, 32'd0);
            a_valid = 1'b0;
            b_valid = 1'b0;
            return;
        end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        n = 0;
        while (!(s3 ? b_rsp_valid : a_rsp_valid) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            chk("rsp_timeout", 32'd1, 32'd0);
            return;
        end
        rd = s3 ? b_rdata : a_rdata;
        er = s3 ? b_err : a_err;
        tick();
        chk("rsp_pulse", {31'd0, s3 ? b_rsp_valid : a_rsp_valid}, 32'd0);
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vt[17];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;

        vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_3FFC, 32'h0,         32'h0000_0000, 1'b0};
        vt[1]  = '{1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vt[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_3003, 32'h0,         32'h0000_0012, 1'b0};
        vt[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_3002, 32'h0,         32'h0000_1234, 1'b0};
        vt[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_3000, 32'h0,         32'h0000_0078, 1'b0};
        vt[5]  = '{1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_0081, 32'h0000_0000, 1'b0};
        vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0,         32'h1234_8178, 1'b0};
        vt[7]  = '{1'b0, 2'd0, 1'b0, 32'h0000_3001, 32'h0,         32'hFFFF_FF81, 1'b0};
        vt[8]  = '{1'b0, 2'd0, 1'b1, 32'h0000_3001, 32'h0,         32'h0000_0081, 1'b0};
        vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_3001, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
        vt[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0,         32'h1234_8178, 1'b0};
        vt[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0,         32'h0000_0000, 1'b1};
        vt[12] = '{1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'h0,         32'h0000_0000, 1'b1};
        vt[13] = '{1'b0, 2'd1, 1'b0, 32'h0000_3000, 32'h0,         32'hFFFF_8178, 1'b0};
        vt[14] = '{1'b0, 2'd1, 1'b1, 32'h0000_3000, 32'h0,         32'h0000_8178, 1'b0};
        vt[15] = '{1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'h5555_ABCD, 32'h0000_0000, 1'b0};
        vt[16] = '{1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0,         32'hABCD_8178, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd1);
        reset = 1'b0;

        // Clear sweep: 4096 edges
        repeat (4095) tick();
        chk("clear_busy_4095", {31'd0, a_busy}, 32'd1);
        chk("clear_ready_4095", {31'd0, a_ready}, 32'd0);
        tick();
        chk("clear_busy_4096", {31'd0, a_busy}, 32'd0);
        chk("clear_ready_4096", {31'd0, a_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            do_req(1'b0, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vt[i].err});
        end

        // LATENCY=3 timing with a request held across WAIT into RESP
        b_we = 1'b1; b_size = 2'd2; b_uns = 1'b0; b_addr = 32'h0000_3000; b_wdata = 32'h1122_3344;
        b_valid = 1'b1;
        chk("l3_ready_pre", {31'd0, b_ready}, 32'd1);
        tick();
        chk("l3_ready_e0", {31'd0, b_ready}, 32'd0);
        chk("l3_vld_e0", {31'd0, b_rsp_valid}, 32'd0);
        b_we = 1'b0; b_wdata = 32'd0;
        tick();
        chk("l3_ready_e1", {31'd0, b_ready}, 32'd0);
        chk("l3_vld_e1", {31'd0, b_rsp_valid}, 32'd0);
        tick();
        chk("l3_vld_e2", {31'd0, b_rsp_valid}, 32'd0);
        tick();
        chk("l3_vld_e3", {31'd0, b_rsp_valid}, 32'd1);
        chk("l3_err_e3", {31'd0, b_err}, 32'd0);
        chk("l3_rdata_e3", b_rdata, 32'd0);
        chk("l3_ready_e3", {31'd0, b_ready}, 32'd0);
        b_valid = 1'b0;
        tick();
        chk("l3_vld_e4", {31'd0, b_rsp_valid}, 32'd0);
        tick();
        chk("l3_vld_e5", {31'd0, b_rsp_valid}, 32'd0);
        tick();
        chk("l3_vld_e6", {31'd0, b_rsp_valid}, 32'd1);
        chk("l3_rdata_e6", b_rdata, 32'h1122_3344);
        tick();
        chk("l3_vld_e7", {31'd0, b_rsp_valid}, 32'd0);

        // Reset while a LATENCY=3 store waits
        b_we = 1'b1; b_size = 2'd2; b_addr = 32'h0000_3000; b_wdata = 32'hDEAD_BEEF; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("rw_ready_wait", {31'd0, b_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rw_busy_async", {31'd0, b_busy}, 32'd1);
        tick();
        tick();
        chk("rw_vld_in_reset", {31'd0, b_rsp_valid}, 32'd0);
        reset = 1'b0;
        n = 0;
        while (b_busy && n < 5000) begin
            tick();
            n++;
        end
        chk("rw_reclear_done", {31'd0, b_busy}, 32'd0);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0, rd, er);
        chk("rw_lw3_rdata", rd, 32'd0);
        chk("rw_lw3_err", {31'd0, er}, 32'd0);
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0, rd, er);
        chk("rw_lw1_rdata", rd, 32'd0);

        // Normal store at pc 0x3010 (traced when DM_TRACE_EN is defined)
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, rd, er);
        chk("sw_dead_err", {31'd0, er}, 32'd0);
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0, rd, er);
        chk("lw_dead_rdata", rd, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
